// File: rtl/student_fir_requant.sv
// Requantiser between the FIR accumulator and the codec DAC path: programmable
// arithmetic right shift with optional round-half-up, 16-bit saturation, and clip/peak statistics.
module student_fir_requant #(
    parameter int DATA_SIZE_FIR_OUT = 32,
    parameter int DATA_SIZE         = 16,
    parameter int SHIFT_WIDTH       = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] y_in,
    input  logic                         valid_strobe_in,
    input  logic [SHIFT_WIDTH-1:0]       shift_i,
    input  logic                         round_en_i,
    input  logic                         clear_i,
    output logic [DATA_SIZE-1:0]         sample_out,
    output logic                         valid_strobe_out,
    output logic                         clip_o,
    output logic [15:0]                  clip_count_o,
    output logic [DATA_SIZE-1:0]         peak_o
);

    // One guard bit so the rounding add can never wrap.
    localparam int EXT_W = DATA_SIZE_FIR_OUT + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX   = EXT_W'(2 ** (DATA_SIZE - 1) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic [DATA_SIZE-1:0]    OUT_MAX   = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0]    OUT_MIN   = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [15:0]             COUNT_MAX = 16'hFFFF;

    logic [EXT_W-1:0]        round_term;
    logic signed [EXT_W-1:0] s1_sum;
    logic [SHIFT_WIDTH-1:0]  s1_shift;
    logic                    s1_valid;

    logic signed [EXT_W-1:0] shifted;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [DATA_SIZE-1:0]    sample_next;
    logic [DATA_SIZE-1:0]    abs_next;

    logic                    clip_next;
    logic [15:0]             count_next;
    logic [DATA_SIZE-1:0]    peak_next;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        round_term = '0;
        if (round_en_i && (shift_i != '0)) begin
            round_term = EXT_W'(1) << (shift_i - 1'b1);
        end
    end

    // NOTE: only the valid bit needs reset; the datapath registers are qualified by it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_strobe_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_strobe_in) begin
            s1_sum   <= $signed({y_in[DATA_SIZE_FIR_OUT-1], y_in} + round_term);
            s1_shift <= shift_i;
        end
    end

    always_comb begin
        shifted     = s1_sum >>> s1_shift;
        sat_hi      = shifted > SAT_MAX;
        sat_lo      = shifted < SAT_MIN;
        sample_next = shifted[DATA_SIZE-1:0];
        if (sat_hi) begin
            sample_next = OUT_MAX;
        end else if (sat_lo) begin
            sample_next = OUT_MIN;
        end
        // Two's-complement negate of the most negative code wraps to 2^(DATA_SIZE-1), read as unsigned.
        abs_next = sample_next[DATA_SIZE-1] ? (~sample_next + DATA_SIZE'(1)) : sample_next;
    end

    // A clear coincident with an output discards the old statistics before folding in the new sample.
    always_comb begin
        clip_next  = clear_i ? 1'b0 : clip_o;
        count_next = clear_i ? '0 : clip_count_o;
        peak_next  = clear_i ? '0 : peak_o;
        if (s1_valid) begin
            if (sat_hi || sat_lo) begin
                clip_next = 1'b1;
                if (count_next != COUNT_MAX) begin
                    count_next = count_next + 16'd1;
                end
            end
            if (abs_next > peak_next) begin
                peak_next = abs_next;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_out       <= '0;
            valid_strobe_out <= 1'b0;
            clip_o           <= 1'b0;
            clip_count_o     <= '0;
            peak_o           <= '0;
        end else begin
            valid_strobe_out <= s1_valid;
            if (s1_valid) begin
                sample_out <= sample_next;
            end
            clip_o       <= clip_next;
            clip_count_o <= count_next;
            peak_o       <= peak_next;
        end
    end

endmodule
